// File: rtl/range_image_loader_if.sv
// range_image_loader_if
// Read-transaction bus between the range-image loader and external memory.
//   readAddress  byte address of the requested 8-byte record
//   initReadTxn  request level, held until readTxnDone
//   readTxnDone  one-cycle completion strobe; readPayload is valid in the same cycle
//   readPayload  64-bit record {x[15:0], y[7:0], 8'bx, range[15:0], 16'bx}
// master: the loader; slave: the memory side.
interface range_image_loader_if;
    logic [31:0] readAddress;
    logic        initReadTxn;
    logic        readTxnDone;
    logic [63:0] readPayload;

    modport master (
        output readAddress,
        output initReadTxn,
        input  readTxnDone,
        input  readPayload
    );

    modport slave (
        input  readAddress,
        input  initReadTxn,
        output readTxnDone,
        output readPayload
    );
endinterface

// File: rtl/range_image_loader.sv
// range_image_loader
// Fetches packed LiDAR point records from external memory, one record per read
// transaction at 8-byte stride, and writes each point's range into the
// range-image BRAM at y*2^IMG_W_LOG2 + x. Points with x or y outside the image
// are counted as dropped. Optionally zeroes the whole image first.
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_start, i_clear      start request (IDLE only); clear-before-load flag
//   i_base_addr           byte address of record 0 (bits [2:0] ignored)
//   i_num_points          records to load (0 allowed)
//   EXT_MEM               external-memory read bus (master side)
//   bram_wr_*             BRAM write port
//   o_busy, o_done        busy level; one-cycle end-of-job pulse
//   o_dropped             out-of-bounds records in the current/last job
module range_image_loader #(
    parameter int unsigned IMG_W_LOG2 = 11,
    parameter int unsigned IMG_H      = 128,
    parameter int unsigned BRAM_AW    = 19
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_clear,
    input  logic [31:0]          i_base_addr,
    input  logic [18:0]          i_num_points,
    range_image_loader_if.master EXT_MEM,
    output logic [BRAM_AW-1:0]   bram_wr_address,
    output logic [15:0]          bram_wr_data,
    output logic                 bram_wr_en,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [18:0]          o_dropped
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_REQ,
        S_WAIT,
        S_WRITE,
        S_FINISH
    } state_t;

    // The clear sweep covers every pixel of the image: IMG_H rows of 2^IMG_W_LOG2.
    localparam logic [BRAM_AW-1:0] CLEAR_LAST = BRAM_AW'((IMG_H << IMG_W_LOG2) - 1);
    localparam logic [16:0]        X_LIM      = 17'(1 << IMG_W_LOG2);
    localparam logic [8:0]         Y_LIM      = 9'(IMG_H);

    state_t              state_q, state_d;
    logic [31:0]         base_q, base_d;
    logic [18:0]         num_q, num_d;
    logic [18:0]         idx_q, idx_d;
    logic [31:0]         rd_addr_q, rd_addr_d;
    logic                rd_req_q, rd_req_d;
    logic [BRAM_AW-1:0]  wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [18:0]         dropped_q, dropped_d;

    logic [15:0]         pay_x;
    logic [7:0]          pay_y;
    logic [15:0]         pay_range;
    logic                pay_in_bounds;
    logic [31:0]         pix_lin;
    logic [18:0]         idx_inc;

    always_comb begin
        pay_x         = EXT_MEM.readPayload[63:48];
        pay_y         = EXT_MEM.readPayload[47:40];
        pay_range     = EXT_MEM.readPayload[31:16];
        pay_in_bounds = ({1'b0, pay_x} < X_LIM) && ({1'b0, pay_y} < Y_LIM);
        pix_lin       = ({24'd0, pay_y} << IMG_W_LOG2) | {16'd0, pay_x};
        idx_inc       = idx_q + 19'd1;
    end

    // Every output is a register loaded with the value belonging to the state
    // being entered, so each output is valid for the whole cycle of its state.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        num_d     = num_q;
        idx_d     = idx_q;
        rd_addr_d = rd_addr_q;
        rd_req_d  = rd_req_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        dropped_d = dropped_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    base_d    = i_base_addr & ~32'h7;
                    num_d     = i_num_points;
                    idx_d     = '0;
                    dropped_d = '0;
                    if (i_clear) begin
                        state_d   = S_CLEAR;
                        wr_en_d   = 1'b1;
                        wr_addr_d = '0;
                        wr_data_d = '0;
                    end else if (i_num_points != '0) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_CLEAR: begin
                // The write address register doubles as the sweep counter.
                if (wr_addr_q == CLEAR_LAST) begin
                    state_d = (num_q != '0) ? S_REQ : S_FINISH;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    wr_data_d = '0;
                end
            end
            S_REQ: begin
                rd_addr_d = base_q + {10'd0, idx_q, 3'b000};
                rd_req_d  = 1'b1;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (EXT_MEM.readTxnDone) begin
                    rd_req_d = 1'b0;
                    state_d  = S_WRITE;
                    if (pay_in_bounds) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = BRAM_AW'(pix_lin);
                        wr_data_d = pay_range;
                    end else if (dropped_q != '1) begin
                        dropped_d = dropped_q + 19'd1;
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_inc;
                state_d = (idx_inc == num_q) ? S_FINISH : S_REQ;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FINISH);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            rd_addr_q <= '0;
            rd_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            num_q     <= num_d;
            idx_q     <= idx_d;
            rd_addr_q <= rd_addr_d;
            rd_req_q  <= rd_req_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dropped_q <= dropped_d;
        end
    end

    assign EXT_MEM.readAddress = rd_addr_q;
    assign EXT_MEM.initReadTxn = rd_req_q;
    assign bram_wr_address     = wr_addr_q;
    assign bram_wr_data        = wr_data_q;
    assign bram_wr_en          = wr_en_q;
    assign o_busy              = busy_q;
    assign o_done              = done_q;
    assign o_dropped           = dropped_q;
endmodule

// File: tb/tb_range_image_loader.sv
// Testbench for range_image_loader. The image is reduced to 8 rows of 2048
// columns so a full clear sweep stays short; bounds follow the same parameters.
module tb_range_image_loader;
    localparam int unsigned W_LOG2 = 11;
    localparam int unsigned H      = 8;
    localparam int unsigned AW     = 14;
    localparam int unsigned NPIX   = H << W_LOG2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          clr;
    logic [31:0]   base;
    logic [18:0]   num;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_en;
    logic          busy;
    logic          done;
    logic [18:0]   dropped;

    range_image_loader_if bus();

    range_image_loader #(
        .IMG_W_LOG2(W_LOG2),
        .IMG_H     (H),
        .BRAM_AW   (AW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_clear        (clr),
        .i_base_addr    (base),
        .i_num_points   (num),
        .EXT_MEM        (bus.master),
        .bram_wr_address(wr_addr),
        .bram_wr_data   (wr_data),
        .bram_wr_en     (wr_en),
        .o_busy         (busy),
        .o_done         (done),
        .o_dropped      (dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { int unsigned x; int unsigned y; logic [15:0] rng; } rec_t;
    typedef struct { int cyc; int unsigned addr; logic [15:0] data; } wr_t;

    rec_t        recs[$];
    logic [63:0] ext_mem [logic [31:0]];
    wr_t         wr_log[$];
    logic [31:0] rd_log[$];
    int          done_log[$];
    int          busy_cyc;
    int          busy_fall_cyc;
    bit          busy_seen;
    int          resp_delay = 0;
    bit          resp_hold  = 1'b0;
    bit          spurious   = 1'b0;

    wr_t         exp_wr[$];
    int          exp_drop;

    // Monitor: log writes, done pulses and busy edges with their cycle number.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                w.cyc = cyc; w.addr = 32'(wr_addr); w.data = wr_data;
                wr_log.push_back(w);
            end
            if (done === 1'b1) done_log.push_back(cyc);
            if (busy === 1'b1 && !busy_seen) begin busy_seen = 1'b1; busy_cyc = cyc; end
            if (busy_seen && busy === 1'b0 && busy_fall_cyc < 0) busy_fall_cyc = cyc;
        end
    end

    // External memory responder; resp_delay extra WAIT cycles (<0: random 0..3).
    initial begin
        int wcnt;
        int lim;
        wcnt = 0; lim = 0;
        bus.readTxnDone = 1'b0;
        bus.readPayload = '0;
        forever begin
            @(negedge clk);
            bus.readTxnDone = 1'b0;
            if (bus.initReadTxn === 1'b1 && !resp_hold) begin
                if (wcnt == 0) lim = (resp_delay < 0) ? int'($urandom_range(3, 0)) : resp_delay;
                wcnt++;
                if (wcnt > lim) begin
                    bus.readTxnDone = 1'b1;
                    bus.readPayload = ext_mem.exists(bus.readAddress) ? ext_mem[bus.readAddress] : '1;
                    rd_log.push_back(bus.readAddress);
                    wcnt = 0;
                end
            end else begin
                if (bus.initReadTxn !== 1'b1) wcnt = 0;
                if (spurious && bus.initReadTxn !== 1'b1 && $urandom_range(1, 0) == 1) begin
                    bus.readTxnDone = 1'b1;
                    bus.readPayload = {16'd1, 8'd1, 8'd0, 16'hDEAD, 16'd0};
                end
            end
        end
    end

    function automatic rec_t rand_rec(input bit allow_oob);
        rec_t r;
        r.x   = $urandom_range(2047, 0);
        r.y   = $urandom_range(H - 1, 0);
        r.rng = 16'($urandom);
        if (allow_oob && $urandom_range(3, 0) == 0) begin
            if ($urandom_range(1, 0) == 1) r.x = $urandom_range(65535, 2048);
            else                           r.y = $urandom_range(255, H);
        end
        return r;
    endfunction

    // Place recs in memory at 8-byte stride from the aligned base (mod 2^32).
    task automatic load_recs(input logic [31:0] b);
        logic [31:0] a;
        ext_mem.delete();
        a = b & ~32'h7;
        foreach (recs[i]) begin
            ext_mem[a] = {16'(recs[i].x), 8'(recs[i].y), 8'($urandom), recs[i].rng, 16'($urandom)};
            a = a + 32'd8;
        end
    endtask

    // Reference: in-bounds points write y*2048+x in record order, others drop.
    task automatic model_job();
        wr_t w;
        exp_wr.delete();
        exp_drop = 0;
        foreach (recs[i]) begin
            if (recs[i].x < (1 << W_LOG2) && recs[i].y < H) begin
                w.cyc = 0; w.addr = recs[i].y * 2048 + recs[i].x; w.data = recs[i].rng;
                exp_wr.push_back(w);
            end else begin
                exp_drop++;
            end
        end
    endtask

    task automatic run_job(input bit c, input logic [31:0] b, input logic [18:0] n,
                           input int max_cyc, input bit poke, output int sc);
        int k;
        wr_log.delete(); rd_log.delete(); done_log.delete();
        busy_seen = 1'b0; busy_fall_cyc = -1;
        @(negedge clk);
        clr = c; base = b; num = n; start = 1'b1; sc = cyc;
        @(negedge clk);
        start = 1'b0; clr = 1'($urandom); base = $urandom; num = 19'($urandom);
        k = 0;
        while (done_log.size() == 0 && k < max_cyc) begin
            @(negedge clk);
            k++;
            if (poke && k == 2) begin start = 1'b1; clr = 1'b1; num = 19'd7; base = 32'h5555_5550; end
            else start = 1'b0;
        end
        start = 1'b0;
        if (done_log.size() == 0) begin
            total++; bad++;
            $display("FAIL job_timeout: no o_done within %0d cycles", max_cyc);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; clr = 1'b0; base = '0; num = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, wr_en, bus.initReadTxn} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, wr_en, bus.initReadTxn});
        end
        total++;
        if ({dropped, wr_addr, wr_data, bus.readAddress} !== '0) begin
            bad++; $display("FAIL reset_data: dropped=%0d addr=%0d data=%h raddr=%h want 0",
                            dropped, wr_addr, wr_data, bus.readAddress);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int sc;
        rec_t r;
        recs.delete();
        r.x = 5; r.y = 3; r.rng = 16'hABCD; recs.push_back(r);
        load_recs(32'h1000_0000);
        resp_delay = 1;
        run_job(1'b0, 32'h1000_0000, 19'd1, 50, 1'b0, sc);
        total++;
        if (rd_log.size() != 1 || rd_log[0] !== 32'h1000_0000) begin
            bad++; $display("FAIL single_read: n=%0d addr=%h want n=1 addr=10000000", rd_log.size(), rd_log[0]);
        end
        total++;
        if (wr_log.size() != 1 || wr_log[0].addr != 6149 || wr_log[0].data !== 16'hABCD) begin
            bad++; $display("FAIL single_write: n=%0d addr=%0d data=%h want n=1 addr=6149 data=abcd",
                            wr_log.size(), wr_log[0].addr, wr_log[0].data);
        end
        total++;
        if (dropped !== 19'd0) begin bad++; $display("FAIL single_dropped: got %0d want 0", dropped); end
        total++;
        if (busy_cyc != sc + 1) begin bad++; $display("FAIL single_busy_latency: got %0d want %0d", busy_cyc - sc, 1); end
        total++;
        if (done_log.size() != 1 || done_log[0] != wr_log[0].cyc + 1) begin
            bad++; $display("FAIL single_done: pulses=%0d at %0d want 1 at %0d", done_log.size(), done_log[0], wr_log[0].cyc + 1);
        end
        total++;
        if (busy_fall_cyc != done_log[0] + 1) begin
            bad++; $display("FAIL single_busy_fall: got %0d want %0d", busy_fall_cyc, done_log[0] + 1);
        end
    endtask

    task automatic test_stream();
        int sc, errs;
        logic [31:0] b, ea;
        recs.delete();
        repeat (4) recs.push_back(rand_rec(1'b0));
        b = $urandom;
        load_recs(b);
        model_job();
        resp_delay = 0;
        run_job(1'b0, b, 19'd4, 60, 1'b0, sc);
        for (int i = 0; i < 4; i++) begin
            ea = (b & ~32'h7) + 32'(8 * i);
            total++;
            if (i >= rd_log.size() || rd_log[i] !== ea) begin
                bad++; $display("FAIL stream_read%0d: got %h want %h", i, (i < rd_log.size()) ? rd_log[i] : 32'hx, ea);
            end
        end
        errs = 0;
        if (wr_log.size() != exp_wr.size()) errs++;
        else foreach (exp_wr[i]) if (wr_log[i].addr != exp_wr[i].addr || wr_log[i].data !== exp_wr[i].data) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL stream_writes: %0d wrong, got n=%0d want n=%0d", errs, wr_log.size(), exp_wr.size()); end
        total++;
        if (wr_log.size() != 4 || wr_log[3].cyc - busy_cyc + 1 != 12) begin
            bad++; $display("FAIL stream_cycles: got %0d want 12", wr_log[wr_log.size() - 1].cyc - busy_cyc + 1);
        end
        total++;
        if (done_log.size() != 1 || done_log[0] != wr_log[wr_log.size() - 1].cyc + 1) begin
            bad++; $display("FAIL stream_done: got %0d want %0d", done_log[0], wr_log[wr_log.size() - 1].cyc + 1);
        end
    endtask

    task automatic test_bounds();
        int sc;
        rec_t r;
        recs.delete();
        r.x = 2047; r.y = 7; r.rng = 16'h1234; recs.push_back(r);
        r.x = 2048; r.y = 0; r.rng = 16'h5678; recs.push_back(r);
        r.x = 0;    r.y = 8; r.rng = 16'h9ABC; recs.push_back(r);
        load_recs(32'h0000_2000);
        resp_delay = -1;
        run_job(1'b0, 32'h0000_2000, 19'd3, 80, 1'b0, sc);
        total++;
        if (wr_log.size() != 1 || wr_log[0].addr != 16383 || wr_log[0].data !== 16'h1234) begin
            bad++; $display("FAIL bounds_write: n=%0d addr=%0d data=%h want n=1 addr=16383 data=1234",
                            wr_log.size(), wr_log[0].addr, wr_log[0].data);
        end
        total++;
        if (dropped !== 19'd2) begin bad++; $display("FAIL bounds_dropped: got %0d want 2", dropped); end
    endtask

    task automatic test_wrap();
        int sc;
        recs.delete();
        repeat (2) recs.push_back(rand_rec(1'b0));
        load_recs(32'hFFFF_FFFB);
        resp_delay = 0;
        run_job(1'b0, 32'hFFFF_FFFB, 19'd2, 40, 1'b0, sc);
        total++;
        if (rd_log.size() != 2 || rd_log[0] !== 32'hFFFF_FFF8 || rd_log[1] !== 32'h0) begin
            bad++; $display("FAIL wrap_reads: n=%0d a0=%h a1=%h want fffffff8 00000000", rd_log.size(), rd_log[0], rd_log[1]);
        end
    endtask

    task automatic test_zero();
        int sc;
        run_job(1'b0, 32'h100, 19'd0, 10, 1'b0, sc);
        total++;
        if (rd_log.size() != 0 || wr_log.size() != 0) begin
            bad++; $display("FAIL zero_activity: reads=%0d writes=%0d want 0 0", rd_log.size(), wr_log.size());
        end
        total++;
        if (done_log.size() != 1 || done_log[0] != sc + 1 || busy_cyc != sc + 1 || busy_fall_cyc != sc + 2) begin
            bad++; $display("FAIL zero_timing: done=%0d busy=%0d fall=%0d want %0d %0d %0d",
                            done_log[0] - sc, busy_cyc - sc, busy_fall_cyc - sc, 1, 1, 2);
        end
    endtask

    task automatic test_start_busy();
        int sc, errs;
        logic [31:0] b;
        recs.delete();
        repeat (3) recs.push_back(rand_rec(1'b1));
        b = 32'h0040_0000;
        load_recs(b);
        model_job();
        resp_delay = 1;
        spurious = 1'b1;
        run_job(1'b0, b, 19'd3, 80, 1'b1, sc);
        spurious = 1'b0;
        total++;
        if (rd_log.size() != 3 || rd_log[0] !== b || rd_log[1] !== b + 32'd8 || rd_log[2] !== b + 32'd16) begin
            bad++; $display("FAIL busy_start_reads: n=%0d want 3 from %h", rd_log.size(), b);
        end
        errs = 0;
        if (wr_log.size() != exp_wr.size()) errs++;
        else foreach (exp_wr[i]) if (wr_log[i].addr != exp_wr[i].addr || wr_log[i].data !== exp_wr[i].data) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL busy_start_writes: %0d wrong, got n=%0d want n=%0d", errs, wr_log.size(), exp_wr.size()); end
        total++;
        if (done_log.size() != 1 || dropped !== 19'(exp_drop)) begin
            bad++; $display("FAIL busy_start_done: pulses=%0d dropped=%0d want 1 %0d", done_log.size(), dropped, exp_drop);
        end
    endtask

    task automatic test_random();
        int sc, errs, n;
        logic [31:0] b;
        rec_t r;
        for (int j = 0; j < 6; j++) begin
            recs.delete();
            n = $urandom_range(24, 1);
            for (int i = 0; i < n; i++) begin
                r = rand_rec(1'b1);
                if (i > 0 && $urandom_range(3, 0) == 0) begin
                    r.x = recs[i - 1].x; r.y = recs[i - 1].y;
                end
                recs.push_back(r);
            end
            b = $urandom;
            load_recs(b);
            model_job();
            resp_delay = -1;
            run_job(1'b0, b, 19'(n), 400, 1'b0, sc);
            errs = 0;
            if (wr_log.size() != exp_wr.size()) errs++;
            else foreach (exp_wr[i]) if (wr_log[i].addr != exp_wr[i].addr || wr_log[i].data !== exp_wr[i].data) errs++;
            total++;
            if (errs != 0) begin bad++; $display("FAIL random%0d_writes: %0d wrong, got n=%0d want n=%0d", j, errs, wr_log.size(), exp_wr.size()); end
            total++;
            if (dropped !== 19'(exp_drop) || rd_log.size() != n) begin
                bad++; $display("FAIL random%0d_counts: dropped=%0d reads=%0d want %0d %0d", j, dropped, rd_log.size(), exp_drop, n);
            end
        end
    endtask

    task automatic test_reset_mid();
        int k, sc;
        recs.delete();
        repeat (3) recs.push_back(rand_rec(1'b0));
        load_recs(32'h0000_8000);
        resp_hold = 1'b1;
        @(negedge clk);
        clr = 1'b0; base = 32'h0000_8000; num = 19'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (bus.initReadTxn !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        total++;
        if (bus.initReadTxn !== 1'b1) begin bad++; $display("FAIL rstmid_req: initReadTxn=%b want 1", bus.initReadTxn); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, wr_en, bus.initReadTxn, dropped, wr_addr, wr_data, bus.readAddress} !== '0) begin
            bad++; $display("FAIL rstmid_outputs: busy=%b req=%b raddr=%h want all 0", busy, bus.initReadTxn, bus.readAddress);
        end
        rst = 1'b0;
        resp_hold = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b0 || bus.initReadTxn !== 1'b0) begin
            bad++; $display("FAIL rstmid_idle: busy=%b req=%b want 0 0", busy, bus.initReadTxn);
        end
        model_job();
        resp_delay = 0;
        run_job(1'b0, 32'h0000_8000, 19'd3, 60, 1'b0, sc);
        total++;
        if (wr_log.size() != 3 || wr_log[2].addr != exp_wr[2].addr || wr_log[2].data !== exp_wr[2].data || done_log.size() != 1) begin
            bad++; $display("FAIL rstmid_rerun: writes=%0d done=%0d want 3 1", wr_log.size(), done_log.size());
        end
    endtask

    task automatic test_clear();
        int sc, errs;
        run_job(1'b1, 32'h0, 19'd0, NPIX + 20, 1'b0, sc);
        errs = 0;
        if (wr_log.size() != NPIX) errs++;
        else foreach (wr_log[i]) if (wr_log[i].addr != i || wr_log[i].data !== 16'h0 || wr_log[i].cyc != sc + 1 + i) errs++;
        total++;
        if (errs != 0) begin bad++; $display("FAIL clear_sweep: writes=%0d bad=%0d want %0d consecutive zero writes", wr_log.size(), errs, NPIX); end
        total++;
        if (rd_log.size() != 0 || done_log.size() != 1 || done_log[0] != sc + 1 + int'(NPIX)) begin
            bad++; $display("FAIL clear_done: reads=%0d done_at=%0d want 0 %0d", rd_log.size(), done_log[0] - sc, NPIX + 1);
        end
    endtask

    task automatic test_clear_load();
        int sc, errs;
        recs.delete();
        repeat (2) recs.push_back(rand_rec(1'b0));
        load_recs(32'h0001_0000);
        model_job();
        resp_delay = -1;
        run_job(1'b1, 32'h0001_0000, 19'd2, NPIX + 40, 1'b0, sc);
        errs = 0;
        if (wr_log.size() != NPIX + 2) errs++;
        else begin
            for (int i = 0; i < int'(NPIX); i++) if (wr_log[i].addr != i || wr_log[i].data !== 16'h0) errs++;
            for (int i = 0; i < 2; i++)
                if (wr_log[NPIX + i].addr != exp_wr[i].addr || wr_log[NPIX + i].data !== exp_wr[i].data) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL clear_load: writes=%0d bad=%0d want %0d", wr_log.size(), errs, NPIX + 2); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clr = 1'b0; base = '0; num = '0;
        test_reset();
        test_single();
        test_stream();
        test_bounds();
        test_wrap();
        test_zero();
        test_start_busy();
        test_random();
        test_reset_mid();
        test_clear();
        test_clear_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
